// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : bram_stream_reader
// Description : Read-side initiator for one port of a 1-cycle-latency BRAM.
//               On start, reads a run of consecutive words (wrapping modulo
//               Depth) and emits them as a valid/ready stream through a
//               2-entry output FIFO that absorbs read latency and stalls.
//               Optional feature macro: BRAM_READER_LAST_EN (adds data_last_o,
//               a final-beat flag carried through the FIFO with its word).
// Revision    : 1.0 - initial release
// ============================================================================
module bram_stream_reader #(
    parameter int DataWidth = 8,
    parameter int Depth     = 1024,
    parameter int AddrWidth = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic [AddrWidth-1:0] length_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [AddrWidth-1:0] bram_addr_o,
    output logic                 bram_write_en_o,
    input  logic [DataWidth-1:0] bram_data_i,
    output logic [DataWidth-1:0] data_o,
`ifdef BRAM_READER_LAST_EN
    output logic                 data_last_o,
`endif
    output logic                 valid_o,
    input  logic                 ready_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [AddrWidth-1:0] C_DEPTH    = AddrWidth'(Depth);
    localparam logic [AddrWidth-1:0] C_LAST_ADR = AddrWidth'(Depth - 1);

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [AddrWidth-1:0]   remaining_q, remaining_d;
    logic                   inflight_q, inflight_d;
    logic [DataWidth-1:0]   fifo_data_q [2];
    logic [DataWidth-1:0]   fifo_data_d [2];
    logic                   rd_ptr_q, rd_ptr_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic [1:0]             count_q, count_d;
`ifdef BRAM_READER_LAST_EN
    logic                   inflight_last_q, inflight_last_d;
    logic                   fifo_last_q [2];
    logic                   fifo_last_d [2];
`endif

    logic                   pop;
    logic                   push;
    logic                   issue;
    logic [2:0]             occupancy;
    logic [2:0]             issue_limit;
    logic [AddrWidth-1:0]   next_addr;
    logic [AddrWidth-1:0]   len_clamped;

    // Handshake, occupancy bookkeeping and the read-issue decision.
    // A read is issued by letting the BRAM sample the current address and
    // advancing it; its data arrives on the next cycle and is pushed then,
    // so one in-flight slot is enough to keep one beat per cycle.
    always_comb begin
        pop         = (count_q != 2'd0) & ready_i;
        push        = inflight_q;
        occupancy   = {1'b0, count_q} + {2'b0, inflight_q};
        issue_limit = 3'd2 + {2'b0, pop};
        issue       = (state_q == ST_RUN) && (remaining_q != '0) && (occupancy < issue_limit);
        next_addr   = (addr_q == C_LAST_ADR) ? '0 : addr_q + AddrWidth'(1);
        len_clamped = (length_i > C_DEPTH) ? C_DEPTH : length_i;
    end

    // Next-state and datapath updates for the controller and the FIFO.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        inflight_d  = 1'b0;
        fifo_data_d = fifo_data_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q + {1'b0, push} - {1'b0, pop};
`ifdef BRAM_READER_LAST_EN
        inflight_last_d = 1'b0;
        fifo_last_d     = fifo_last_q;
`endif

        if (push) begin
            fifo_data_d[wr_ptr_q] = bram_data_i;
`ifdef BRAM_READER_LAST_EN
            fifo_last_d[wr_ptr_q] = inflight_last_q;
`endif
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        if (issue) begin
            addr_d      = next_addr;
            remaining_d = remaining_q - AddrWidth'(1);
            inflight_d  = 1'b1;
`ifdef BRAM_READER_LAST_EN
            inflight_last_d = (remaining_q == AddrWidth'(1));
`endif
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    addr_d      = base_addr_i;
                    remaining_d = len_clamped;
                    state_d     = (len_clamped == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue && (remaining_q == AddrWidth'(1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Finished once the last beat leaves and nothing is still coming.
                if (!inflight_q && (count_q == {1'b0, pop})) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            fifo_data_q <= '{default: '0};
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
`ifdef BRAM_READER_LAST_EN
            inflight_last_q <= 1'b0;
            fifo_last_q     <= '{default: 1'b0};
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            fifo_data_q <= fifo_data_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
`ifdef BRAM_READER_LAST_EN
            inflight_last_q <= inflight_last_d;
            fifo_last_q     <= fifo_last_d;
`endif
        end
    end

    assign busy_o          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done_o          = (state_q == ST_DONE);
    assign bram_addr_o     = addr_q;
    assign bram_write_en_o = 1'b0;
    assign valid_o         = (count_q != 2'd0);
    assign data_o          = fifo_data_q[rd_ptr_q];
`ifdef BRAM_READER_LAST_EN
    assign data_last_o     = valid_o & fifo_last_q[rd_ptr_q];
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_stream_reader
// Description : Self-checking bench for bram_stream_reader (Depth=16). A
//               queue-based reference model predicts beats, timing and
//               handshake outputs; directed tests pin the model with literals.
//               Define BRAM_READER_LAST_EN to also check data_last_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_stream_reader;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic          ready_i = 1'b1;
    logic [AW-1:0] base_addr_i = '0;
    logic [AW-1:0] length_i = '0;
    logic          busy_o, done_o, bram_write_en_o, valid_o;
    logic [AW-1:0] bram_addr_o;
    logic [DW-1:0] bram_data_i = '0;
    logic [DW-1:0] data_o;
`ifdef BRAM_READER_LAST_EN
    logic          data_last_o;
    logic          last_log [$];
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int ready_mode = 0;

    logic [DW-1:0] mem [0:31];

    bram_stream_reader #(.DataWidth(DW), .Depth(DEPTH), .AddrWidth(AW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .base_addr_i    (base_addr_i),
        .length_i       (length_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .bram_addr_o    (bram_addr_o),
        .bram_write_en_o(bram_write_en_o),
        .bram_data_i    (bram_data_i),
        .data_o         (data_o),
`ifdef BRAM_READER_LAST_EN
        .data_last_o    (data_last_o),
`endif
        .valid_o        (valid_o),
        .ready_i        (ready_i)
    );

    always #5 clk = ~clk;

    // BRAM: registered read, data valid the cycle after its address.
    always @(posedge clk) bram_data_i <= mem[bram_addr_o];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit            m_active, m_done_due, m_got_first, m_ready_all, m_prev_stall;
    logic [DW-1:0] m_prev_data;
    logic [DW-1:0] m_q [$];
    logic [DW-1:0] beat_log [$];
    int            cyc = 0;
    int            m_start_cyc, m_first_due, m_addr_chk_cyc;
    int            first_lat = -1;
    int            m_last_addr;

    always @(negedge clk) begin
        bit exp_done;
        bit idle;
        int l;
        cyc++;
        if (!rst_ni) begin
            check("rst_valid", valid_o, 0);
            check("rst_busy", busy_o, 0);
            check("rst_done", done_o, 0);
            check("rst_data", data_o, 0);
            check("rst_addr", bram_addr_o, 0);
`ifdef BRAM_READER_LAST_EN
            check("rst_last", data_last_o, 0);
`endif
            m_active = 0; m_done_due = 0; m_got_first = 0; m_prev_stall = 0;
            m_q.delete();
        end else begin
            exp_done   = m_done_due;
            m_done_due = 0;
            idle       = !m_active && !exp_done;
            check("done", done_o, exp_done);
            check("busy", busy_o, m_active);
            check("wen", bram_write_en_o, 0);
            if (m_q.size() == 0) check("valid_empty", valid_o, 0);
            if (m_prev_stall) begin
                check("stall_valid", valid_o, 1);
                check("stall_data", data_o, m_prev_data);
            end
            if (m_active && !m_got_first) begin
                if (cyc < m_first_due) check("early_valid", valid_o, 0);
                else begin
                    check("first_valid", valid_o, 1);
                    m_got_first = 1;
                end
            end else if (m_active && m_ready_all && m_q.size() > 0) begin
                check("stream_valid", valid_o, 1);
            end
            if (m_active && valid_o && first_lat < 0) first_lat = cyc - m_start_cyc;
            if (m_active && cyc == m_addr_chk_cyc) begin
                check("addr_base", bram_addr_o, m_last_addr);
            end else if (m_active && cyc > m_addr_chk_cyc && int'(bram_addr_o) != m_last_addr) begin
                check("addr_step", bram_addr_o, (m_last_addr + 1) % DEPTH);
                m_last_addr = int'(bram_addr_o);
            end
            if (valid_o && m_q.size() > 0) begin
                check("data", data_o, m_q[0]);
`ifdef BRAM_READER_LAST_EN
                check("last", data_last_o, (m_q.size() == 1) ? 1 : 0);
`endif
            end
`ifdef BRAM_READER_LAST_EN
            if (!valid_o) check("last_idle", data_last_o, 0);
`endif
            // model updates
            m_prev_stall = valid_o && !ready_i;
            m_prev_data  = data_o;
            if (!ready_i) m_ready_all = 0;
            if (valid_o && ready_i && m_q.size() > 0) begin
                beat_log.push_back(data_o);
`ifdef BRAM_READER_LAST_EN
                last_log.push_back(data_last_o);
`endif
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_done_due = 1;
                    m_active   = 0;
                end
            end
            if (start_i && idle) begin
                l = (length_i > DEPTH) ? DEPTH : int'(length_i);
                m_q.delete();
                for (int i = 0; i < l; i++) m_q.push_back(mem[(int'(base_addr_i) + i) % DEPTH]);
                m_start_cyc    = cyc;
                m_first_due    = cyc + 3;
                m_addr_chk_cyc = cyc + 1;
                m_last_addr    = int'(base_addr_i);
                m_got_first    = 0;
                m_ready_all    = 1;
                first_lat      = -1;
                if (l == 0) m_done_due = 1;
                else        m_active   = 1;
            end
        end
    end

    // ready driver: mode 0 always ready, mode 1 repeating 1,0,0,1
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk); #1;
            ready_i = (ready_mode == 0) ? 1'b1 : ((ph % 4 == 0) || (ph % 4 == 3));
            ph++;
        end
    end

    task automatic do_start(input int base, input int len);
        @(posedge clk); #1;
        base_addr_i = AW'(base);
        length_i    = AW'(len);
        start_i     = 1'b1;
        @(posedge clk); #1;
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (done_o !== 1'b1 && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        check(name, done_o, 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_log(input string name, input int base, input int n);
        check({name, "_count"}, beat_log.size(), n);
        for (int i = 0; i < n && i < beat_log.size(); i++)
            check({name, "_beat"}, beat_log[i], (base + i) % DEPTH);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < 32; i++) mem[i] = (i < DEPTH) ? DW'(i) : 8'hEE;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        repeat (2) @(posedge clk);

        // basic read: 0,1,2,3 with 3-cycle start-to-valid
        beat_log.delete();
        do_start(0, 4);
        wait_done("basic_done", 50);
        check_log("basic", 0, 4);
        check("basic_latency", first_lat, 3);

        // wrap-around: 14,15,0,1
        beat_log.delete();
        do_start(14, 4);
        wait_done("wrap_done", 50);
        check("wrap_b0", beat_log.size() > 0 ? beat_log[0] : 8'hFF, 14);
        check("wrap_b2", beat_log.size() > 2 ? beat_log[2] : 8'hFF, 0);
        check_log("wrap", 14, 4);

        // backpressure
        beat_log.delete();
        ready_mode = 1;
        do_start(2, 8);
        wait_done("bp_done", 100);
        ready_mode = 0;
        check_log("bp", 2, 8);

        // zero length
        beat_log.delete();
        do_start(3, 0);
        wait_done("zero_done", 5);
        check("zero_beats", beat_log.size(), 0);

        // start pulsed mid-RUN is ignored
        beat_log.delete();
        do_start(3, 6);
        repeat (2) @(posedge clk);
        do_start(9, 2);
        wait_done("ign_done", 50);
        check_log("ign", 3, 6);
        repeat (4) @(posedge clk);
        check("ign_no_restart", beat_log.size(), 6);

        // length clamped to Depth
        beat_log.delete();
        do_start(0, 20);
        wait_done("clamp_done", 80);
        check_log("clamp", 0, 16);

        // reset during beat 3 of 8
        beat_log.delete();
        do_start(0, 8);
        k = 0;
        while (beat_log.size() < 2 && k < 50) begin @(posedge clk); #2; k++; end
        check("pre_rst_valid", valid_o, 1);
        check("pre_rst_data", data_o, 2);
        rst_ni = 1'b0;
        #1;
        check("arst_valid", valid_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_data", data_o, 0);
        check("arst_addr", bram_addr_o, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_ni = 1'b1;
        repeat (2) @(posedge clk);
        beat_log.delete();
        do_start(5, 2);
        wait_done("post_rst_done", 50);
        check_log("post_rst", 5, 2);

`ifdef BRAM_READER_LAST_EN
        last_log.delete();
        do_start(0, 3);
        wait_done("last3_done", 50);
        check("last3_n", last_log.size(), 3);
        for (int i = 0; i < last_log.size(); i++)
            check("last3_flag", last_log[i], (i == 2) ? 1 : 0);
        last_log.delete();
        do_start(7, 1);
        wait_done("last1_done", 50);
        check("last1_n", last_log.size(), 1);
        check("last1_flag", last_log.size() > 0 ? last_log[0] : 1'b0, 1);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
